// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing rules and parameter legality checks for sync_fifo_flags
package fifo_pkg;
  function automatic int depth_f(input int address);
    return 1 << address;
  endfunction
  function automatic int count_w_f(input int address);
    return address + 1;
  endfunction
  function automatic bit af_legal_f(input int af, input int address);
    return af >= 1 && af <= depth_f(address);
  endfunction
  function automatic bit ae_legal_f(input int ae, input int address);
    return ae >= 0 && ae < depth_f(address);
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: Width x Depth dual-port array, synchronous write and asynchronous read
// Ports: clk_i clock; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
module fifo_mem import fifo_pkg::*; #(
  parameter int Width   = 32,
  parameter int Address = 3
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [Address-1:0] waddr_i,
  input  logic [Width-1:0]   wdata_i,
  input  logic [Address-1:0] raddr_i,
  output logic [Width-1:0]   rdata_o
);
  logic [Width-1:0] mem_q [depth_f(Address)];
  always_ff @(posedge clk_i) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count-based flags and registered or fall-through read
// Ports: clk_i clock; reset_i sync active-low reset; write_i/write_data_i push;
// read_i pop (FWFT: head acknowledge); read_data_o/read_valid_o read side;
// full_o/empty_o/almost_full_o/almost_empty_o/count_o status; overflow_o/underflow_o error pulses.
module sync_fifo_flags import fifo_pkg::*; #(
  parameter int Width     = 32,
  parameter int Address   = 3,
  parameter int AF_Thresh = 6,
  parameter int AE_Thresh = 1,
  parameter int FWFT      = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          write_i,
  input  logic                          read_i,
  input  logic [Width-1:0]              write_data_i,
  output logic [Width-1:0]              read_data_o,
  output logic                          read_valid_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          almost_full_o,
  output logic                          almost_empty_o,
  output logic [count_w_f(Address)-1:0] count_o,
  output logic                          overflow_o,
  output logic                          underflow_o
);
  localparam int Depth = depth_f(Address);
  localparam int CW = count_w_f(Address);
  if (!af_legal_f(AF_Thresh, Address)) begin : g_af_chk
    $error("AF_Thresh must lie in 1..Depth");
  end
  if (!ae_legal_f(AE_Thresh, Address)) begin : g_ae_chk
    $error("AE_Thresh must lie in 0..Depth-1");
  end
  logic [Address-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [Width-1:0] rdata_q, rdata_d, mem_rdata;
  logic full_q, empty_q, af_q, ae_q, ovf_q, unf_q, rvalid_q, wr_en, rd_en;
  fifo_mem #(.Width(Width), .Address(Address)) u_mem (
    .clk_i  (clk_i),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(write_data_i),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rdata)
  );
  // acceptance uses this cycle's registered flags, so a pop never frees room for a same-cycle push
  always_comb begin
    wr_en = write_i && !full_q;
    rd_en = read_i && !empty_q;
    wr_ptr_d = wr_en ? wr_ptr_q + Address'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + Address'(1) : rd_ptr_q;
    count_d = (wr_en && !rd_en) ? count_q + CW'(1) : (rd_en && !wr_en) ? count_q - CW'(1) : count_q;
    rdata_d = rd_en ? mem_rdata : rdata_q;
  end
  // flags are computed from count_d so they line up with count_q in the same cycle
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= count_d == CW'(Depth);
      empty_q  <= count_d == '0;
      af_q     <= count_d >= CW'(AF_Thresh);
      ae_q     <= count_d <= CW'(AE_Thresh);
      ovf_q    <= write_i && full_q;
      unf_q    <= read_i && empty_q;
      rvalid_q <= rd_en;
      rdata_q  <= rdata_d;
    end
  end
  assign read_data_o    = FWFT != 0 ? mem_rdata : rdata_q;
  assign read_valid_o   = FWFT != 0 ? !empty_q : rvalid_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: registered and fall-through instances driven in lockstep against a queue model
module tb_sync_fifo_flags;
  logic clk = 1'b0, rst_n = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] wd = '0, rdata0, rdata1;
  logic [1:0] full, empty, af, ae, ovf, unf, rv;
  logic [3:0] cnt [2];
  int checks = 0, errors = 0;
  logic [7:0] q [$];
  logic [7:0] exp_rd0 = '0;
  bit exp_rv0, exp_ovf, exp_unf;

  always #5 clk = ~clk;

  sync_fifo_flags #(.Width(8), .Address(3), .AF_Thresh(6), .AE_Thresh(1), .FWFT(0)) dut0 (
    .clk_i(clk), .reset_i(rst_n), .write_i(wr), .read_i(rd), .write_data_i(wd),
    .read_data_o(rdata0), .read_valid_o(rv[0]), .full_o(full[0]), .empty_o(empty[0]),
    .almost_full_o(af[0]), .almost_empty_o(ae[0]), .count_o(cnt[0]),
    .overflow_o(ovf[0]), .underflow_o(unf[0])
  );
  sync_fifo_flags #(.Width(8), .Address(3), .AF_Thresh(6), .AE_Thresh(1), .FWFT(1)) dut1 (
    .clk_i(clk), .reset_i(rst_n), .write_i(wr), .read_i(rd), .write_data_i(wd),
    .read_data_o(rdata1), .read_valid_o(rv[1]), .full_o(full[1]), .empty_o(empty[1]),
    .almost_full_o(af[1]), .almost_empty_o(ae[1]), .count_o(cnt[1]),
    .overflow_o(ovf[1]), .underflow_o(unf[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count%0d", i), 32'(cnt[i]), n);
      chk($sformatf("full%0d", i), 32'(full[i]), 32'(n == 8));
      chk($sformatf("empty%0d", i), 32'(empty[i]), 32'(n == 0));
      chk($sformatf("afull%0d", i), 32'(af[i]), 32'(n >= 6));
      chk($sformatf("aempty%0d", i), 32'(ae[i]), 32'(n <= 1));
      chk($sformatf("overflow%0d", i), 32'(ovf[i]), 32'(exp_ovf));
      chk($sformatf("underflow%0d", i), 32'(unf[i]), 32'(exp_unf));
    end
    chk("rvalid_reg", 32'(rv[0]), 32'(exp_rv0));
    chk("rdata_reg", 32'(rdata0), 32'(exp_rd0));
    chk("rvalid_fwft", 32'(rv[1]), 32'(n != 0));
    if (n != 0) chk("rdata_fwft", 32'(rdata1), 32'(q[0]));
  endtask

  task automatic cycle(input bit r_n, input bit w, input bit r, input logic [7:0] d);
    int n;
    @(negedge clk);
    rst_n = r_n; wr = w; rd = r; wd = d;
    @(posedge clk);
    n = q.size();
    if (!r_n) begin
      q.delete();
      exp_rd0 = '0; exp_rv0 = 0; exp_ovf = 0; exp_unf = 0;
    end else begin
      exp_ovf = w && n == 8;
      exp_unf = r && n == 0;
      exp_rv0 = r && n != 0;
      if (exp_rv0) exp_rd0 = q.pop_front();
      if (w && n != 8) q.push_back(d);
    end
    #1 check_all();
  endtask

  initial begin
    bit w, r;
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 8'h99);
    for (int i = 1; i <= 8; i++) cycle(1, 1, 0, 8'(i * 17));
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 8'($urandom));
    cycle(1, 1, 0, 8'hF0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 8'($urandom));
    cycle(1, 1, 1, 8'hEE);
    for (int i = 0; i < 7; i++) cycle(1, 0, 1, 0);
    cycle(1, 1, 1, 8'hA5);
    cycle(1, 0, 1, 0);
    cycle(1, 1, 0, 8'h3C);
    cycle(1, 1, 0, 8'h7E);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      w = 1'($urandom);
      r = 1'($urandom);
      if (q.size() >= 5) w = 0;
      if (q.size() <= 3) r = 0;
      cycle(1, w, r, 8'($urandom));
    end
    cycle(1, 1, 1, 8'($urandom));
    cycle(0, 1, 1, 8'hDD);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 8'($urandom));
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0);
    for (int i = 0; i < 300; i++) begin
      w = $urandom_range(0, 99) < 55;
      r = $urandom_range(0, 99) < 50;
      cycle($urandom_range(0, 59) != 0, w, r, 8'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO with count-based status: occupancy output, programmable almost-full/almost-empty thresholds, overflow/underflow pulses and a selectable read mode (registered or first-word-fall-through). It is the next-generation drop-in for the existing synchronous FIFO top. It sits between a producer and consumer in one clock domain, typically in front of stream consumers that need early back-pressure.

## Interface
- Width, 32, data word width in bits
- Address, 3, pointer width; Depth = 2**Address entries
- AF_Thresh, 6, Almost_Full asserts when Count >= AF_Thresh (legal 1..Depth)
- AE_Thresh, 1, Almost_Empty asserts when Count <= AE_Thresh (legal 0..Depth-1)
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- Write  in  1  write request
- Read  in  1  read request (FWFT=1: acknowledge of current head)
- Write_Data  in  Width  data to store
- Read_Data  out  Width  read data
- Read_Valid  out  1  Read_Data holds valid data
- Full  out  1  Count == Depth
- Empty  out  1  Count == 0
- Almost_Full  out  1  Count >= AF_Thresh
- Almost_Empty  out  1  Count <= AE_Thresh
- Count  out  Address+1  current occupancy, 0..Depth
- Overflow  out  1  one-cycle pulse: Write while Full
- Underflow  out  1  one-cycle pulse: Read while Empty

## Operation
- Write accepted iff Write && !Full. The entry is stored at wr_ptr and wr_ptr increments mod Depth.
- Read accepted iff Read && !Empty. The entry is taken from rd_ptr and rd_ptr increments mod Depth.
- Acceptance uses the registered flags of the current cycle.
  - Write while Full is dropped, even with an accepted Read in the same cycle.
  - Read while Empty is rejected, even with an accepted Write in the same cycle.
- Count update per cycle:
  - +1 if only the write is accepted
  - -1 if only the read is accepted
  - unchanged if both or neither are accepted
- All flags are registered and derived from the next-cycle Count, so they always agree with Count in the same cycle.
- Pointers wrap naturally at Depth; Full/Empty come from Count, never from pointer comparison.
- Rejected requests:
  - Overflow = registered (Write && Full)
  - Underflow = registered (Read && Empty)
  - Neither changes state.
- FWFT=0 (registered read):
  - an accepted read loads Read_Data with mem[rd_ptr] and sets Read_Valid for exactly the next cycle
  - otherwise Read_Valid=0 and Read_Data holds its last value
- FWFT=1 (fall-through):
  - Read_Data = mem[rd_ptr] combinationally
  - Read_Valid = !Empty
  - an accepted Read pops the head, and the next entry is presented the following cycle
- Reset (reset==0 at a clk edge), from any state, including mid-burst:
  - wr_ptr, rd_ptr and Count = 0
  - Empty=1, Full=0
  - Almost_Empty=1; Almost_Full=0 (AF_Thresh >= 1)
  - Read_Valid=0, Read_Data=0 (FWFT=0), Overflow=0, Underflow=0
  - Memory contents are not reset.
  - Requests in the reset cycle are ignored.

## Timing
- Write-to-status latency is 1 cycle: a write accepted at edge N gives Count=1 and Empty=0 after edge N.
- FWFT=1: the first word is visible on Read_Data in the cycle after the write edge.
- FWFT=0 read latency is 1 cycle, from the Read-accept edge to the Read_Valid cycle.
- Back-to-back reads or writes every cycle are sustained at full throughput.
- Simultaneous read and write when Full: the read is accepted, the write is dropped, Overflow pulses, and Count becomes Depth-1.
- Simultaneous read and write when Empty: the write is accepted, the read is rejected, Underflow pulses, and Count becomes 1.

## Structure
- Shared package fifo_pkg holds:
  - the constant function for Depth (2**Address)
  - the Count width rule (Address+1)
  - parameter legality checks for AF_Thresh and AE_Thresh (elaboration-time error if out of range)
- One sub-module, fifo_mem: Width x Depth dual-port array with a synchronous write port and an asynchronous read port.
- The top holds the pointers, Count, flag registers, error pulses and the FWFT read mux.

## Test plan
- Width=8, Address=3, FWFT=0: reset, write 0x11..0x88 (8 writes), then 8 reads:
  - Full=1 after the 8th write, with Almost_Full first at Count=6
  - reads return 0x11..0x88 in order, each with a one-cycle Read_Valid
  - Empty=1 and Count=0 at the end
- Fill to Full, then Write=1 for one cycle: Overflow pulses 1 cycle, Count stays 8, and the data order is unchanged on drain.
- Full with Read=Write=1 for one cycle: Count=7, Overflow=1, and the new word is absent on drain.
- Empty with Read=Write=1 and data 0xA5: Underflow=1, Count=1, and a later read returns 0xA5.
- FWFT=1: write 0x3C, then 0x7E:
  - Read_Data=0x3C with Read_Valid=1 the cycle after the first write
  - Read pops it, and 0x7E appears the next cycle
- Wrap and reset: run 20 interleaved write/read cycles at Count 3-5, verifying ordering across pointer wrap; assert reset mid-burst; check that all outputs reach their reset values the next cycle and that the old data is never read back.
